// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the core and its data-memory responder.
package rv32i_pkg;

  // Data-path word width.
  localparam int WORD_W = 32;

  // Internal opcode classes. The core decoder and the responder must agree
  // on which classes are loads and which are stores.
  localparam logic [3:0] OP_ALU    = 4'd0;
  localparam logic [3:0] OP_ALUI   = 4'd1;
  localparam logic [3:0] OP_LUI    = 4'd2;
  localparam logic [3:0] OP_AUIPC  = 4'd3;
  localparam logic [3:0] OP_JAL    = 4'd4;
  localparam logic [3:0] OP_BRANCH = 4'd5;
  localparam logic [3:0] OP_LOAD   = 4'd6;
  localparam logic [3:0] OP_STORE  = 4'd7;
  localparam logic [3:0] OP_JALR   = 4'd8;
  localparam logic [3:0] OP_SYSTEM = 4'd9;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  // True when a word index falls inside a memory of 'depth' words.
  function automatic logic word_in_range(input logic [WORD_W-1:0] idx,
                                         input int unsigned       depth);
    return idx < WORD_W'(depth);
  endfunction

endpackage

// File: rtl/rv32i_dm_array.sv
// Single-port DEPTH x 32 data array with synchronous read.
// Read data only updates on an enabled read, so it holds steady while the
// responder sits in RESP.
module rv32i_dm_array
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Enabled write or registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the core's MEM stage: one outstanding request,
// programmable wait states, then a response held until the initiator takes it.
module rv32i_dmem_responder
  import rv32i_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;
  logic              accept;
  logic              arr_en;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_INIT != 4'd0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        // Guard on <=1 so a corrupted zero count cannot wedge the FSM.
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and request capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= !word_in_range(req_addr, DEPTH);
      end
    end
  end

  // Out-of-range requests never touch the array, so they cannot alias
  // onto a valid index through the truncated address bits.
  assign arr_en = (state_q == ACCESS) && !err_q;

  rv32i_dm_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (we_q),
    .addr_i  (addr_q[ADDR_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Response outputs are built from registered state only, so they stay
  // stable for the whole RESP stay.
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? arr_rdata : '0;

endmodule
